// File: rtl/vlw_pkg.sv
// Shared definitions for the vector load writeback block.
// Holds the lane geometry, the lane vector type, the FSM state enum and a
// helper that recognises the read-only PC alias destination.
package vlw_pkg;

    localparam int LANES  = 16;
    localparam int DATA_W = 32;
    localparam int LANE_W = 4;

    // Register index 15 aliases the PC and cannot take a scalar write.
    localparam logic [3:0] PC_ALIAS_IDX = 4'd15;

    typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } vlw_state_e;

    function automatic logic is_pc_alias_write(input logic vec, input logic [3:0] dst);
        return (!vec && (dst == PC_ALIAS_IDX));
    endfunction

endpackage

// File: rtl/vlw_lane_buffer.sv
// Capture registers for one vector: LANES x DATA_W words.
// Ports:
//   clk      - clock
//   rst      - synchronous active-low reset
//   clr      - synchronous clear of all lanes
//   lane_idx - lane written when cap_en is high
//   cap_en   - capture enable
//   cap_data - word captured into lane lane_idx
//   buf_q    - parallel view of all lanes
module vlw_lane_buffer
    import vlw_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [LANE_W-1:0] lane_idx,
    input  logic              cap_en,
    input  logic [DATA_W-1:0] cap_data,
    output lane_vec_t         buf_q
);

    lane_vec_t buf_r;

    // Lane storage: clear on reset or new command, otherwise capture one lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_r <= '0;
        end else if (clr) begin
            buf_r <= '0;
        end else if (cap_en) begin
            buf_r[lane_idx] <= cap_data;
        end else begin
            buf_r <= buf_r;
        end
    end

    assign buf_q = buf_r;

endmodule

// File: rtl/vector_load_writeback.sv
// Sequences a scalar or vector load (one 32-bit read per lane) and presents
// the gathered result to the register file write port as a one-cycle write.
// Optional feature: define VLW_STRIDE_EN to add the req_stride port; the
// stride is then latched per command instead of using parameter STRIDE.
// Ports:
//   clk, rst                    - clock, synchronous active-low reset
//   req_valid/req_ready         - command handshake (ready only in IDLE)
//   req_addr, req_dst, req_vec  - base address, dest index, vector/scalar
//   req_stride                  - per-command stride (VLW_STRIDE_EN only)
//   mem_req/mem_addr/mem_gnt    - read request channel
//   mem_rvalid/mem_rdata        - read response channel
//   we3, ra3, wd3, selec_v_s_w  - register file write port
//   done, err                   - completion pulse, PC-alias rejection pulse
module vector_load_writeback
    import vlw_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_dst,
    input  logic              req_vec,
`ifdef VLW_STRIDE_EN
    input  logic [ADDR_W-1:0] req_stride,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              we3,
    output logic [3:0]        ra3,
    output lane_vec_t         wd3,
    output logic              selec_v_s_w,
    output logic              done,
    output logic              err
);

    vlw_state_e        state_r;
    vlw_state_e        state_nxt_s;

    logic [LANE_W-1:0] lane_r;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [3:0]        dst_r;
    logic              vec_r;
    logic [ADDR_W-1:0] stride_s;

    logic              accept_s;
    logic              capture_s;
    logic              last_lane_s;
    logic              reject_s;
    logic              commit_s;

    logic              req_ready_nxt_s;
    logic              mem_req_nxt_s;
    logic              we3_nxt_s;
    logic              done_nxt_s;
    logic              err_nxt_s;

    logic              req_ready_r;
    logic              mem_req_r;
    logic              we3_r;
    logic              done_r;
    logic              err_r;
    logic [3:0]        ra3_r;
    lane_vec_t         wd3_r;
    logic              selec_r;

    lane_vec_t         buf_q_s;
    lane_vec_t         wd3_nxt_s;

`ifdef VLW_STRIDE_EN
    logic [ADDR_W-1:0] stride_r;

    // Per-command stride latched at accept; zero gives a broadcast load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stride_r <= '0;
        end else if (accept_s) begin
            stride_r <= req_stride;
        end else begin
            stride_r <= stride_r;
        end
    end

    assign stride_s = stride_r;
`else
    assign stride_s = ADDR_W'(STRIDE);
`endif

    assign accept_s    = (state_r == IDLE) && req_valid;
    assign capture_s   = (state_r == WAIT) && mem_rvalid;
    assign last_lane_s = vec_r ? (lane_r == LANE_W'(LANES - 1)) : (lane_r == '0);
    assign reject_s    = is_pc_alias_write(vec_r, dst_r);
    assign commit_s    = capture_s && last_lane_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; stray gnt/rvalid in the wrong state are ignored.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt_s = last_lane_s ? WRITE : ISSUE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WRITE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the handshake outputs leave flops.
    always_comb begin
        req_ready_nxt_s = 1'b0;
        mem_req_nxt_s   = 1'b0;
        we3_nxt_s       = 1'b0;
        done_nxt_s      = 1'b0;
        err_nxt_s       = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                req_ready_nxt_s = 1'b1;
            end
            ISSUE: begin
                mem_req_nxt_s = 1'b1;
            end
            WAIT: begin
                mem_req_nxt_s = 1'b0;
            end
            WRITE: begin
                done_nxt_s = 1'b1;
                we3_nxt_s  = !reject_s;
                err_nxt_s  = reject_s;
            end
            default: begin
                req_ready_nxt_s = 1'b0;
            end
        endcase
    end

    // Final write data: buffered lanes with the lane arriving this cycle merged in.
    always_comb begin
        wd3_nxt_s         = buf_q_s;
        wd3_nxt_s[lane_r] = mem_rdata;
    end

    // Command context, lane counter and address walk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_r     <= '0;
            cur_addr_r <= '0;
            dst_r      <= 4'd0;
            vec_r      <= 1'b0;
        end else if (accept_s) begin
            lane_r     <= '0;
            cur_addr_r <= req_addr;
            dst_r      <= req_dst;
            vec_r      <= req_vec;
        end else if (capture_s && !last_lane_s) begin
            lane_r     <= lane_r + LANE_W'(1);
            cur_addr_r <= cur_addr_r + stride_s;
        end else begin
            lane_r     <= lane_r;
            cur_addr_r <= cur_addr_r;
        end
    end

    // Registered port outputs; write payload only changes on a real write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_ready_r <= 1'b1;
            mem_req_r   <= 1'b0;
            we3_r       <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            ra3_r       <= 4'd0;
            wd3_r       <= '0;
            selec_r     <= 1'b0;
        end else begin
            req_ready_r <= req_ready_nxt_s;
            mem_req_r   <= mem_req_nxt_s;
            we3_r       <= we3_nxt_s;
            done_r      <= done_nxt_s;
            err_r       <= err_nxt_s;
            if (commit_s && !reject_s) begin
                ra3_r   <= dst_r;
                wd3_r   <= wd3_nxt_s;
                selec_r <= vec_r;
            end else begin
                ra3_r   <= ra3_r;
                wd3_r   <= wd3_r;
                selec_r <= selec_r;
            end
        end
    end

    vlw_lane_buffer u_lane_buffer (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept_s),
        .lane_idx (lane_r),
        .cap_en   (capture_s),
        .cap_data (mem_rdata),
        .buf_q    (buf_q_s)
    );

    assign req_ready   = req_ready_r;
    assign mem_req     = mem_req_r;
    assign mem_addr    = cur_addr_r;
    assign we3         = we3_r;
    assign done        = done_r;
    assign err         = err_r;
    assign ra3         = ra3_r;
    assign wd3         = wd3_r;
    assign selec_v_s_w = selec_r;

endmodule

// File: tb/tb_vector_load_writeback.sv
// Self-checking bench for vector_load_writeback. A memory responder driven
// from the bench serves each lane with chosen grant/response delays; the
// expected addresses, write data and write cycle come from the load rules.
module tb_vector_load_writeback;
    import vlw_pkg::*;

    localparam int STRIDE = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_dst;
    logic        req_vec;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        we3;
    logic [3:0]  ra3;
    lane_vec_t   wd3;
    logic        selec_v_s_w;
    logic        done;
    logic        err;
`ifdef VLW_STRIDE_EN
    logic [31:0] req_stride;
`endif

    int n_checks;
    int n_pass;

    int          gd_a [16];
    int          rd_a [16];
    logic [31:0] data_a [16];

    vector_load_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_dst     (req_dst),
        .req_vec     (req_vec),
`ifdef VLW_STRIDE_EN
        .req_stride  (req_stride),
`endif
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .we3         (we3),
        .ra3         (ra3),
        .wd3         (wd3),
        .selec_v_s_w (selec_v_s_w),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_delays();
        for (int i = 0; i < 16; i++) begin
            gd_a[i] = 0;
            rd_a[i] = 0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, 1'b1);
        chk({tag, "_memreq"}, mem_req, 1'b0);
        chk({tag, "_memaddr"}, mem_addr, 32'd0);
        chk({tag, "_we3"}, we3, 1'b0);
        chk({tag, "_ra3"}, ra3, 4'd0);
        chk({tag, "_wd3"}, wd3, 512'd0);
        chk({tag, "_selec"}, selec_v_s_w, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    // One load: exp_lat is the edge (after accept) at which we3/done are sampled.
    // abort_lane >= 0 resets the block while waiting for that lane's data.
    task automatic run_load(input logic [31:0] base, input logic [3:0] dst, input logic vec,
                            input int exp_lat, input bit pulse_req, input int abort_lane);
        int          edges;
        int          nl;
        lane_vec_t   exp_wd;
        logic [31:0] a;
        bit          rej;
        nl     = vec ? 16 : 1;
        rej    = !vec && (dst == 4'd15);
        exp_wd = '0;
        @(negedge clk);
        chk("ready_before", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = base;
        req_dst   = dst;
        req_vec   = vec;
        @(posedge clk);
        edges = 0;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        for (int i = 0; i < nl; i++) begin
            a = base + 32'(i) * 32'(STRIDE);
            for (int g = 0; g <= gd_a[i]; g++) begin
                chk("mem_req", mem_req, 1'b1);
                chk("mem_addr", mem_addr, a);
                chk("busy_ready", req_ready, 1'b0);
                if (pulse_req && i == 5 && g == 1) begin
                    req_valid = 1'b1;
                end
                mem_gnt    = (g == gd_a[i]);
                mem_rvalid = (g != gd_a[i]);
                mem_rdata  = $urandom;
                @(posedge clk);
                edges++;
                @(negedge clk);
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                req_valid  = 1'b0;
            end
            if (i == abort_lane) begin
                rst = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst        = 1'b1;
                mem_rvalid = 1'b1;
                mem_rdata  = data_a[i];
                chk_reset_outputs("after_rst");
                @(posedge clk);
                @(negedge clk);
                mem_rvalid = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    chk("post_rst_we3", we3, 1'b0);
                    chk("post_rst_memreq", mem_req, 1'b0);
                    chk("post_rst_done", done, 1'b0);
                    @(posedge clk);
                    @(negedge clk);
                end
                return;
            end
            for (int r = 0; r <= rd_a[i]; r++) begin
                chk("no_req_wait", mem_req, 1'b0);
                mem_rvalid = (r == rd_a[i]);
                mem_gnt    = (r != rd_a[i]);
                mem_rdata  = mem_rvalid ? data_a[i] : $urandom;
                @(posedge clk);
                edges++;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_gnt    = 1'b0;
            end
            exp_wd[i] = data_a[i];
        end
        chk("latency", edges + 1, exp_lat);
        chk("we3", we3, !rej);
        chk("done", done, 1'b1);
        chk("err", err, rej);
        chk("write_memreq", mem_req, 1'b0);
        if (!rej) begin
            chk("ra3", ra3, dst);
            chk("selec", selec_v_s_w, vec);
            chk("wd3", wd3, exp_wd);
        end
        @(posedge clk);
        @(negedge clk);
        chk("we3_pulse", we3, 1'b0);
        chk("done_pulse", done, 1'b0);
        chk("err_pulse", err, 1'b0);
        chk("ready_after", req_ready, 1'b1);
        if (!rej) begin
            chk("ra3_hold", ra3, dst);
            chk("wd3_hold", wd3, exp_wd);
        end
    endtask

    initial begin
        int nl;
        int lat;
        logic vec;
        logic [3:0] dst;
        clk        = 1'b0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_dst    = 4'd0;
        req_vec    = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        n_checks   = 0;
        n_pass     = 0;
`ifdef VLW_STRIDE_EN
        req_stride = 32'd4;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;

        // Scalar load.
        clr_delays();
        data_a[0] = 32'hDEADBEEF;
        run_load(32'h100, 4'd4, 1'b0, 3, 1'b0, -1);

        // Vector load, lane i returns 0x1000+i.
        for (int i = 0; i < 16; i++) data_a[i] = 32'h1000 + 32'(i);
        run_load(32'h200, 4'd7, 1'b1, 33, 1'b0, -1);

        // Address wrap-around.
        for (int i = 0; i < 16; i++) data_a[i] = $urandom;
        run_load(32'hFFFFFFF8, 4'd2, 1'b1, 33, 1'b0, -1);

        // Scalar write to PC alias is rejected.
        data_a[0] = 32'h12345678;
        run_load(32'h40, 4'd15, 1'b0, 3, 1'b0, -1);

        // Stalled grant on lane 5, stalled response on lane 9, mid-load req pulse.
        for (int i = 0; i < 16; i++) data_a[i] = $urandom;
        gd_a[5] = 3;
        rd_a[9] = 2;
        run_load(32'h300, 4'd9, 1'b1, 38, 1'b1, -1);
        for (int k = 0; k < 3; k++) begin
            chk("no_extra_cmd", mem_req, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end

        // Reset while waiting on lane 7, then a normal command.
        clr_delays();
        for (int i = 0; i < 16; i++) data_a[i] = $urandom;
        run_load(32'h400, 4'd3, 1'b1, 33, 1'b0, 7);
        data_a[0] = 32'hCAFEF00D;
        run_load(32'h500, 4'd1, 1'b0, 3, 1'b0, -1);

        // Randomized loads with random stalls.
        for (int t = 0; t < 8; t++) begin
            vec = 1'($urandom_range(0, 1));
            dst = 4'($urandom_range(0, 15));
            nl  = vec ? 16 : 1;
            lat = 1;
            for (int i = 0; i < 16; i++) begin
                gd_a[i]   = $urandom_range(0, 2);
                rd_a[i]   = $urandom_range(0, 2);
                data_a[i] = $urandom;
                if (i < nl) lat += 2 + gd_a[i] + rd_a[i];
            end
            run_load($urandom, dst, vec, lat, 1'b0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
